gate_vector_checker: RTL and testbench
======================================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter CNT_W, default 8: width of the vec_cnt and err_cnt counters.
REQ-002 Parameter MAX_VECS, default 4: vectors accepted before the block finishes on its own; legal range 1..2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a check run.
REQ-006 stop  input  1  one-cycle pulse that ends the run early.
REQ-007 vec_valid  input  1  a, b and g_res are valid this cycle.
REQ-008 a, b  input  1 each  stimulus applied to the gate stage under test.
REQ-009 g_res  input  7  gate-stage outputs, bit0..6 = {and, or, not(a), nand, nor, xor, xnor}.
REQ-010 busy  output  1  high in RUN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  run verdict, valid while done=1.
REQ-013 vec_cnt  output  CNT_W  vectors accepted this run.
REQ-014 err_cnt  output  CNT_W  vectors with at least one mismatching bit.
REQ-015 cov  output  4  input combinations seen; bit index = {a,b}.
REQ-016 fail_seen  output  1  at least one mismatch captured.
REQ-017 first_fail_vec  output  2  {a,b} of the first failing vector.
REQ-018 first_fail_mask  output  7  g_res XOR expected for the first failing vector.

Function
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 Transitions:
- IDLE->RUN on start.
- DONE->RUN on start.
- RUN->DONE on stop, or when the accepted vector brings vec_cnt to MAX_VECS.
REQ-021 start in RUN is ignored.
REQ-022 Accepting start clears vec_cnt, err_cnt, cov, fail_seen, first_fail_vec and first_fail_mask in the same edge.
REQ-023 A vector is accepted only when vec_valid=1 in RUN; vec_valid in IDLE or DONE has no effect.
REQ-024 Expected value per bit, the truth function of its gate:
- and = a&b, or = a|b, not = ~a, nand = ~(a&b), nor = ~(a|b), xor = a^b, xnor = ~(a^b).
REQ-025 Per accepted vector, all outputs update at the next rising edge (1-cycle latency):
- vec_cnt +1.
- cov bit {a,b} set.
- err_cnt +1 when the mask (g_res XOR expected) is non-zero.
REQ-026 On the first non-zero mask of a run:
- fail_seen is set.
- first_fail_vec and first_fail_mask are captured.
- Later failures leave the capture unchanged.
REQ-027 vec_cnt and err_cnt saturate at all-ones and never wrap.
REQ-028 A vector accepted together with stop, or as the one reaching MAX_VECS, is fully counted and checked before DONE is entered.
REQ-029 stop coinciding with reaching MAX_VECS produces a single RUN->DONE transition.
REQ-030 pass = 1 only in DONE with err_cnt=0 and cov=4'hF; pass = 0 in all other states.
REQ-031 busy, done and pass are registered: no combinational path from inputs to outputs.
REQ-032 All results hold their values in DONE until the next accepted start.

Reset
REQ-033 rst_n low forces, immediately and independent of clk:
- state IDLE.
- busy, done, pass, fail_seen = 0.
- vec_cnt, err_cnt, cov, first_fail_vec, first_fail_mask = 0.
REQ-034 Reset asserted mid-RUN discards the run; after release the block stays in IDLE until start.
REQ-035 Release of rst_n is synchronous to clk; start sampled in the first edge after release is honoured.

Structure
REQ-036 Shared package gate_chk_pkg holds:
- FSM state encoding.
- g_res bit-position constants (AND_B..XNOR_B).
- The all-ones coverage constant 4'hF.
REQ-037 Sub-module gate_ref_model holds the combinational a,b -> 7-bit expected vector; no other sub-modules.

Verification
REQ-038 Reset, then start, then four correct vectors {00,01,10,11} -> auto DONE after the 4th; vec_cnt=4, err_cnt=0, cov=F, pass=1.
REQ-039 Vector a=1, b=0 with g_res bit0 (and) forced to 1 -> err_cnt=1, fail_seen=1, first_fail_vec=2'b10, first_fail_mask=7'b0000001, pass=0.
REQ-040 start, vectors 00 and 01, then stop -> DONE with vec_cnt=2, cov=4'b0011, pass=0.
REQ-041 CNT_W=2, MAX_VECS=3, all three vectors faulty -> err_cnt=3; then a restart with start clears all results to 0.
REQ-042 rst_n pulsed low mid-RUN after 2 vectors -> all outputs read 0 asynchronously; a following vec_valid without start leaves vec_cnt=0.
REQ-043 stop and the MAX_VECS-th vector in the same cycle -> vector counted, one done rise; a start in RUN is ignored (counters not cleared).

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate vector checker: FSM encoding, g_res bit
// positions and the full-coverage constant.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int GRES_W = 7;

  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NOT_B  = 2;
  localparam int NAND_B = 3;
  localparam int NOR_B  = 4;
  localparam int XOR_B  = 5;
  localparam int XNOR_B = 6;

  localparam logic [3:0] COV_ALL = 4'hF;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Bundle between the gate stage under test / run controller (master) and
// the checker (slave).
interface gate_vector_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             vec_valid;
  logic             a;
  logic             b;
  logic [6:0]       g_res;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       cov;
  logic             fail_seen;
  logic [1:0]       first_fail_vec;
  logic [6:0]       first_fail_mask;

  modport master (
    output start, stop, vec_valid, a, b, g_res,
    input  busy, done, pass, vec_cnt, err_cnt, cov,
           fail_seen, first_fail_vec, first_fail_mask
  );

  modport slave (
    input  start, stop, vec_valid, a, b, g_res,
    output busy, done, pass, vec_cnt, err_cnt, cov,
           fail_seen, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/gate_ref_model.sv
// Golden truth functions of the seven-gate stage for one (a, b) pair.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [GRES_W-1:0] exp_o
);

  always_comb begin
    exp_o         = '0;
    exp_o[AND_B]  = a_i & b_i;
    exp_o[OR_B]   = a_i | b_i;
    exp_o[NOT_B]  = ~a_i;
    exp_o[NAND_B] = ~(a_i & b_i);
    exp_o[NOR_B]  = ~(a_i | b_i);
    exp_o[XOR_B]  = a_i ^ b_i;
    exp_o[XNOR_B] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Run controller that compares gate-stage outputs against the reference
// truth functions and accumulates counts, coverage and first-failure capture.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_VECS = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  gate_vector_checker_if.slave bus
);

  logic [GRES_W-1:0] exp_vec;
  logic [GRES_W-1:0] mask;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [3:0]        cov_q, cov_d;
  logic              fail_seen_q, fail_seen_d;
  logic [1:0]        ffv_q, ffv_d;
  logic [GRES_W-1:0] ffm_q, ffm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  gate_ref_model u_ref (
    .a_i   (bus.a),
    .b_i   (bus.b),
    .exp_o (exp_vec)
  );

  assign mask = bus.g_res ^ exp_vec;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    cov_d       = cov_q;
    fail_seen_d = fail_seen_q;
    ffv_d       = ffv_q;
    ffm_d       = ffm_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          vec_cnt_d   = '0;
          err_cnt_d   = '0;
          cov_d       = '0;
          fail_seen_d = 1'b0;
          ffv_d       = '0;
          ffm_d       = '0;
        end
      end
      ST_RUN: begin
        if (bus.vec_valid) begin
          vec_cnt_d = (vec_cnt_q == '1) ? vec_cnt_q : vec_cnt_q + CNT_W'(1);
          cov_d[{bus.a, bus.b}] = 1'b1;
          if (mask != '0) begin
            err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              ffv_d       = {bus.a, bus.b};
              ffm_d       = mask;
            end
          end
        end
        // The vector of this cycle is already folded in, whether it ends the run or not.
        if (bus.stop || (vec_cnt_d == CNT_W'(MAX_VECS))) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == '0) && (cov_d == COV_ALL);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      cov_q       <= '0;
      fail_seen_q <= 1'b0;
      ffv_q       <= '0;
      ffm_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      cov_q       <= cov_d;
      fail_seen_q <= fail_seen_d;
      ffv_q       <= ffv_d;
      ffm_q       <= ffm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.vec_cnt         = vec_cnt_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.cov             = cov_q;
  assign bus.fail_seen       = fail_seen_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (8-bit/4 vectors and
// 2-bit/3 vectors) share stimulus and are compared to a run-level model.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   rises8 = 0;

  always #5 clk = ~clk;

  gate_vector_checker_if #(.CNT_W(8)) if8 ();
  gate_vector_checker_if #(.CNT_W(2)) if2 ();

  gate_vector_checker #(.CNT_W(8), .MAX_VECS(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  gate_vector_checker #(.CNT_W(2), .MAX_VECS(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct {
    bit         run;
    bit         fin;
    int         vcnt;
    int         ecnt;
    logic [3:0] cov;
    bit         fs;
    logic [1:0] ffv;
    logic [6:0] ffm;
  } mdl_t;

  mdl_t m8, m2;

  // Gate truth table from the number of ones on the inputs; bit 6..0 = xnor..and.
  function automatic logic [6:0] truth(bit a, bit b);
    int n;
    n = int'(a) + int'(b);
    return {n != 1, n == 1, n == 0, n != 2, !a, n > 0, n == 2};
  endfunction

  function automatic mdl_t zero_mdl();
    mdl_t m;
    m.run = 0; m.fin = 0; m.vcnt = 0; m.ecnt = 0;
    m.cov = '0; m.fs = 0; m.ffv = '0; m.ffm = '0;
    return m;
  endfunction

  function automatic mdl_t step(mdl_t m, int maxv, int cmax, bit st, bit sp,
                                bit vv, bit a, bit b, logic [6:0] g);
    logic [6:0] mk;
    if (!m.run) begin
      if (st) begin
        m = zero_mdl();
        m.run = 1;
      end
    end else begin
      if (vv) begin
        mk = g ^ truth(a, b);
        if (m.vcnt < cmax) m.vcnt++;
        m.cov[{a, b}] = 1'b1;
        if (mk != 0) begin
          if (m.ecnt < cmax) m.ecnt++;
          if (!m.fs) begin
            m.fs = 1; m.ffv = {a, b}; m.ffm = mk;
          end
        end
      end
      if (sp || m.vcnt == maxv) begin
        m.run = 0;
        m.fin = 1;
      end
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= zero_mdl();
      m2 <= zero_mdl();
    end else begin
      m8 <= step(m8, 4, 255, if8.start, if8.stop, if8.vec_valid, if8.a, if8.b, if8.g_res);
      m2 <= step(m2, 3, 3, if8.start, if8.stop, if8.vec_valid, if8.a, if8.b, if8.g_res);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp(string tag, mdl_t m, logic busy, logic done, logic pass,
                     logic [31:0] vc, logic [31:0] ec, logic [3:0] cov,
                     logic fs, logic [1:0] ffv, logic [6:0] ffm);
    check({tag, ".busy"}, 32'(busy), 32'(m.run));
    check({tag, ".done"}, 32'(done), 32'(m.fin));
    check({tag, ".pass"}, 32'(pass), 32'(m.fin && m.ecnt == 0 && m.cov == 4'hF));
    check({tag, ".vec_cnt"}, vc, 32'(m.vcnt));
    check({tag, ".err_cnt"}, ec, 32'(m.ecnt));
    check({tag, ".cov"}, 32'(cov), 32'(m.cov));
    check({tag, ".fail_seen"}, 32'(fs), 32'(m.fs));
    check({tag, ".ffv"}, 32'(ffv), 32'(m.ffv));
    check({tag, ".ffm"}, 32'(ffm), 32'(m.ffm));
  endtask

  always @(negedge clk) begin
    cmp("d8", m8, if8.busy, if8.done, if8.pass, 32'(if8.vec_cnt), 32'(if8.err_cnt),
        if8.cov, if8.fail_seen, if8.first_fail_vec, if8.first_fail_mask);
    cmp("d2", m2, if2.busy, if2.done, if2.pass, 32'(if2.vec_cnt), 32'(if2.err_cnt),
        if2.cov, if2.fail_seen, if2.first_fail_vec, if2.first_fail_mask);
  end

  always @(posedge if8.done) rises8++;

  task automatic drive(bit st, bit sp, bit vv, bit a, bit b, logic [6:0] g);
    if8.start = st; if8.stop = sp; if8.vec_valid = vv; if8.a = a; if8.b = b; if8.g_res = g;
    if2.start = st; if2.stop = sp; if2.vec_valid = vv; if2.a = a; if2.b = b; if2.g_res = g;
  endtask

  // One clock with the given inputs; returns 2 time units after the edge.
  task automatic apply(bit st, bit sp, bit vv, bit a, bit b, logic [6:0] g);
    drive(st, sp, vv, a, b, g);
    @(posedge clk);
    #2;
    drive(1'b0, 1'b0, 1'b0, a, b, g);
  endtask

  task automatic vec(bit a, bit b, logic [6:0] fault);
    apply(1'b0, 1'b0, 1'b1, a, b, truth(a, b) ^ fault);
  endtask

  task automatic all_zero(string tag);
    check({tag, ".d8_out"}, {if8.busy, if8.done, if8.pass, if8.fail_seen, if8.cov,
          if8.first_fail_vec, if8.first_fail_mask, if8.vec_cnt}, 32'd0);
    check({tag, ".d8_err"}, 32'(if8.err_cnt), 32'd0);
    check({tag, ".d2_out"}, {if2.busy, if2.done, if2.pass, if2.fail_seen, if2.cov,
          if2.first_fail_vec, if2.first_fail_mask, if2.vec_cnt, if2.err_cnt}, 32'd0);
  endtask

  initial begin
    int r0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    #1 rst_n = 1'b0;
    #1 all_zero("reset");
    #20 rst_n = 1'b1;

    // Four correct vectors complete the 4-vector run automatically.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    check("start_after_release", 32'(if8.busy), 32'd1);
    vec(0, 0, 7'd0); vec(0, 1, 7'd0); vec(1, 0, 7'd0); vec(1, 1, 7'd0);
    check("full.vec_cnt", 32'(if8.vec_cnt), 32'd4);
    check("full.err_cnt", 32'(if8.err_cnt), 32'd0);
    check("full.cov", 32'(if8.cov), 32'hF);
    check("full.done_pass", {if8.done, if8.pass}, 32'b11);
    check("d2.max3_cov", 32'(if2.cov), 32'b0111);
    check("d2.max3_vec", 32'(if2.vec_cnt), 32'd3);

    // Single vector 10 with the and-bit forced high.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    check("fault.g_res", 32'(truth(1, 0) | 7'd1), 32'b0101011);
    vec(1, 0, 7'b0000001);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    check("fault.err_cnt", 32'(if8.err_cnt), 32'd1);
    check("fault.fail_seen", 32'(if8.fail_seen), 32'd1);
    check("fault.ffv", 32'(if8.first_fail_vec), 32'b10);
    check("fault.ffm", 32'(if8.first_fail_mask), 32'b0000001);
    check("fault.pass", 32'(if8.pass), 32'd0);

    // Early stop after two vectors.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    vec(0, 0, 7'd0); vec(0, 1, 7'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);
    check("stop.vec_cnt", 32'(if8.vec_cnt), 32'd2);
    check("stop.cov", 32'(if8.cov), 32'b0011);
    check("stop.done_pass", {if8.done, if8.pass}, 32'b10);

    // Three faulty vectors end the narrow instance; restart clears it.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    vec(1, 1, 7'h40); vec(0, 1, 7'h05); vec(1, 0, 7'h10);
    check("d2.err3", 32'(if2.err_cnt), 32'd3);
    check("d2.first_mask", {if2.first_fail_vec, if2.first_fail_mask}, {2'b11, 7'h40});
    check("d2.done", 32'(if2.done), 32'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    check("d2.restart", {if2.vec_cnt, if2.err_cnt, if2.cov, if2.fail_seen,
          if2.first_fail_vec, if2.first_fail_mask}, 32'd0);
    check("d2.restart_busy", 32'(if2.busy), 32'd1);
    check("d8.start_in_run", 32'(if8.vec_cnt), 32'd3);
    apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0);

    // Asynchronous reset in the middle of a run.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    vec(0, 1, 7'd0); vec(1, 1, 7'h02);
    #1 rst_n = 1'b0;
    #1 all_zero("midrun_reset");
    #3 rst_n = 1'b1;
    vec(1, 1, 7'd0);
    check("post_reset.vec_cnt", 32'(if8.vec_cnt), 32'd0);
    check("post_reset.busy", 32'(if8.busy), 32'd0);

    // Start in RUN ignored, then stop together with the 4th vector.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    vec(0, 0, 7'd0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, truth(1, 1));
    check("run_start_ignored", 32'(if8.vec_cnt), 32'd2);
    vec(1, 0, 7'd0);
    r0 = rises8;
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, truth(0, 1));
    check("stop_at_max.vec_cnt", 32'(if8.vec_cnt), 32'd4);
    check("stop_at_max.pass", 32'(if8.pass), 32'd1);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
    check("stop_at_max.done_rises", 32'(rises8 - r0), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit ra, rb;
      logic [6:0] flt;
      ra  = 1'($urandom);
      rb  = 1'($urandom);
      flt = ($urandom % 4 == 0) ? 7'($urandom) : 7'd0;
      apply($urandom % 12 == 0, $urandom % 10 == 0, $urandom % 3 != 0, ra, rb,
            truth(ra, rb) ^ flt);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
